// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - default 640x480@60 VGA timing constants and sync-level helper
package vga_timing_pkg;

    // Default horizontal timing (pixels)
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    // Default vertical timing (lines)
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Sync windows are half-open: [start, end)
    localparam int DEF_HSYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int DEF_HSYNC_END   = DEF_HSYNC_START + DEF_H_SYNC;
    localparam int DEF_VSYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int DEF_VSYNC_END   = DEF_VSYNC_START + DEF_V_SYNC;

    // Pin level for a sync signal: active-low polarity inverts the active flag
    function automatic logic sync_level(input logic active, input logic active_low);
        return active ^ active_low;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-MOD up counter with terminal-count flag
module mod_counter #(
    parameter int MOD = 800,
    parameter int W   = 10
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // wrap flags the terminal count; the caller gates it with its own enable
    assign wrap  = (count_q == LAST);
    assign count = count_q;

    // Next count: advance when enabled, return to zero after the terminal count
    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_timing_controller.sv
// rtl/vga_timing_controller.sv - VGA raster timing generator with registered decode outputs
module vga_timing_controller
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE       = DEF_H_VISIBLE,
    parameter int H_FRONT         = DEF_H_FRONT,
    parameter int H_SYNC          = DEF_H_SYNC,
    parameter int H_BACK          = DEF_H_BACK,
    parameter int V_VISIBLE       = DEF_V_VISIBLE,
    parameter int V_FRONT         = DEF_V_FRONT,
    parameter int V_SYNC          = DEF_V_SYNC,
    parameter int V_BACK          = DEF_V_BACK,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int CW              = 10
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          PIX_EN,
    output logic          H_Display,
    output logic          V_Display,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic [CW-1:0] PIXEL_X,
    output logic [CW-1:0] PIXEL_Y,
    output logic          LINE_START,
    output logic          FRAME_START
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Decode compares run one bit wider so a sync end equal to 2**CW stays representable
    localparam logic [CW:0] H_VIS_L    = (CW+1)'(H_VISIBLE);
    localparam logic [CW:0] HS_START_L = (CW+1)'(H_VISIBLE + H_FRONT);
    localparam logic [CW:0] HS_END_L   = (CW+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CW:0] V_VIS_L    = (CW+1)'(V_VISIBLE);
    localparam logic [CW:0] VS_START_L = (CW+1)'(V_VISIBLE + V_FRONT);
    localparam logic [CW:0] VS_END_L   = (CW+1)'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic        SYNC_POL   = (SYNC_ACTIVE_LOW != 0);

    if (((2 ** CW) < H_TOTAL) || ((2 ** CW) < V_TOTAL)) begin : g_cw_check
        $error("vga_timing_controller: CW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap_unused;
    logic [CW:0]   h_ext;
    logic [CW:0]   v_ext;

    logic          hd_d, hd_q;
    logic          vd_d, vd_q;
    logic          hs_d, hs_q;
    logic          vs_d, vs_q;
    logic [CW-1:0] x_d, x_q;
    logic [CW-1:0] y_d, y_q;
    logic          ls_d, ls_q;
    logic          fs_d, fs_q;

    // Counters hold the position the next PIX_EN edge will present
    mod_counter #(.MOD(H_TOTAL), .W(CW)) u_h_cnt (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .en      (PIX_EN),
        .count   (h_cnt),
        .wrap    (h_wrap)
    );

    mod_counter #(.MOD(V_TOTAL), .W(CW)) u_v_cnt (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .en      (PIX_EN & h_wrap),
        .count   (v_cnt),
        .wrap    (v_wrap_unused)
    );

    assign h_ext = {1'b0, h_cnt};
    assign v_ext = {1'b0, v_cnt};

    // Decode the position about to be presented
    always_comb begin
        hd_d = (h_ext < H_VIS_L);
        vd_d = (v_ext < V_VIS_L);
        hs_d = sync_level((h_ext >= HS_START_L) && (h_ext < HS_END_L), SYNC_POL);
        vs_d = sync_level((v_ext >= VS_START_L) && (v_ext < VS_END_L), SYNC_POL);
        x_d  = h_cnt;
        y_d  = v_cnt;
        ls_d = (h_cnt == '0);
        fs_d = (h_cnt == '0) && (v_cnt == '0);
    end

    // Output registers load on pixel ticks only, so everything holds between ticks
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            hd_q <= 1'b0;
            vd_q <= 1'b0;
            hs_q <= sync_level(1'b0, SYNC_POL);
            vs_q <= sync_level(1'b0, SYNC_POL);
            x_q  <= '0;
            y_q  <= '0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end else if (PIX_EN) begin
            hd_q <= hd_d;
            vd_q <= vd_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            x_q  <= x_d;
            y_q  <= y_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
        end
    end

    assign H_Display   = hd_q;
    assign V_Display   = vd_q;
    assign HSYNC       = hs_q;
    assign VSYNC       = vs_q;
    assign PIXEL_X     = x_q;
    assign PIXEL_Y     = y_q;
    assign LINE_START  = ls_q;
    assign FRAME_START = fs_q;

endmodule

// File: tb/tb_vga_timing_controller.sv
// tb/tb_vga_timing_controller.sv - scoreboard testbench for vga_timing_controller
module tb_vga_timing_controller;

    typedef struct packed {
        logic       hd;
        logic       vd;
        logic       hs;
        logic       vs;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, pe_a, rst_b_n, pe_b;
    logic a_hd, a_vd, a_hs, a_vs, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic b_hd, b_vd, b_hs, b_vs, b_ls, b_fs;
    logic [3:0] b_x, b_y;

    vga_timing_controller u_dut_a (
        .CLK(clk), .RESET_N(rst_a_n), .PIX_EN(pe_a),
        .H_Display(a_hd), .V_Display(a_vd), .HSYNC(a_hs), .VSYNC(a_vs),
        .PIXEL_X(a_x), .PIXEL_Y(a_y), .LINE_START(a_ls), .FRAME_START(a_fs)
    );

    vga_timing_controller #(
        .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_ACTIVE_LOW(0), .CW(4)
    ) u_dut_b (
        .CLK(clk), .RESET_N(rst_b_n), .PIX_EN(pe_b),
        .H_Display(b_hd), .V_Display(b_vd), .HSYNC(b_hs), .VSYNC(b_vs),
        .PIXEL_X(b_x), .PIXEL_Y(b_y), .LINE_START(b_ls), .FRAME_START(b_fs)
    );

    int checks = 0;
    int failures = 0;

    int hv[2]  = '{640, 8};
    int hf[2]  = '{16, 1};
    int hsw[2] = '{96, 2};
    int hb[2]  = '{48, 1};
    int vv[2]  = '{480, 4};
    int vf[2]  = '{10, 1};
    int vsw[2] = '{2, 1};
    int vb[2]  = '{33, 1};
    bit al[2]  = '{1'b1, 1'b0};

    int   m_h[2];
    int   m_v[2];
    obs_t last[2];
    obs_t qa[$];
    obs_t qb[$];

    function automatic obs_t reset_obs(int d);
        obs_t o;
        o    = '0;
        o.hs = al[d];
        o.vs = al[d];
        return o;
    endfunction

    function automatic obs_t decode(int d, int h, int v);
        obs_t o;
        bit   ha, va;
        ha   = (h >= hv[d] + hf[d]) && (h < hv[d] + hf[d] + hsw[d]);
        va   = (v >= vv[d] + vf[d]) && (v < vv[d] + vf[d] + vsw[d]);
        o.hd = (h < hv[d]);
        o.vd = (v < vv[d]);
        o.hs = al[d] ? !ha : ha;
        o.vs = al[d] ? !va : va;
        o.x  = 10'(h);
        o.y  = 10'(v);
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
        return o;
    endfunction

    function automatic obs_t sample(int d);
        obs_t o;
        if (d == 0) o = '{a_hd, a_vd, a_hs, a_vs, a_x, a_y, a_ls, a_fs};
        else        o = '{b_hd, b_vd, b_hs, b_vs, {6'b0, b_x}, {6'b0, b_y}, b_ls, b_fs};
        return o;
    endfunction

    task automatic model_reset(int d);
        m_h[d]  = 0;
        m_v[d]  = 0;
        last[d] = reset_obs(d);
        if (d == 0) qa.delete(); else qb.delete();
    endtask

    // Drive one CLK cycle, push the expected outputs, return #1 after the edge
    task automatic tick(int d, bit pe);
        obs_t e;
        int   ht, vt;
        ht = hv[d] + hf[d] + hsw[d] + hb[d];
        vt = vv[d] + vf[d] + vsw[d] + vb[d];
        if (d == 0) pe_a = pe; else pe_b = pe;
        if (pe) begin
            e = decode(d, m_h[d], m_v[d]);
            m_h[d]++;
            if (m_h[d] == ht) begin
                m_h[d] = 0;
                m_v[d]++;
                if (m_v[d] == vt) m_v[d] = 0;
            end
        end else begin
            e = last[d];
        end
        last[d] = e;
        if (d == 0) qa.push_back(e); else qb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, exp;
        rst_a_n = 1'b0; rst_b_n = 1'b0; pe_a = 1'b1; pe_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        got = sample(0); checks++;
        if (got !== reset_obs(0)) begin failures++; $display("FAIL reset_a: got %h expected %h", got, reset_obs(0)); end
        got = sample(1); checks++;
        if (got !== reset_obs(1)) begin failures++; $display("FAIL reset_b: got %h expected %h", got, reset_obs(1)); end
        rst_a_n = 1'b1;
        model_reset(0);
        tick(0, 1'b1);
        got = sample(0); exp = qa.pop_front(); checks++;
        if (got !== exp) begin failures++; $display("FAIL first_edge: got %h expected %h", got, exp); end
        checks++;
        if (!(got.fs === 1'b1 && got.ls === 1'b1 && got.hd === 1'b1 && got.vd === 1'b1 && got.x === 10'd0 && got.y === 10'd0)) begin
            failures++; $display("FAIL first_edge_fields: got %h expected fs=ls=hd=vd=1 x=y=0", got);
        end
    endtask

    task automatic test_lines();
        obs_t got, exp, prev;
        int hd_cnt = 0, hs_cnt = 0, ls_cnt = 0, ls_prev = -1, fall_x = -1, rise_x = -1;
        prev = sample(0);
        for (int i = 0; i < 1600; i++) begin
            tick(0, 1'b1);
            got = sample(0); exp = qa.pop_front(); checks++;
            if (got !== exp) begin failures++; $display("FAIL line tick %0d: got %h expected %h", i, got, exp); end
            if (got.hd) hd_cnt++;
            if (!got.hs) hs_cnt++;
            if (prev.hs && !got.hs) fall_x = int'(got.x);
            if (!prev.hs && got.hs) rise_x = int'(got.x);
            if (got.ls) begin
                ls_cnt++;
                if (ls_prev >= 0) begin
                    checks++;
                    if (i - ls_prev != 800) begin failures++; $display("FAIL line_start_period: got %0d expected 800", i - ls_prev); end
                end
                ls_prev = i;
            end
            prev = got;
        end
        checks++; if (hd_cnt != 1280) begin failures++; $display("FAIL h_display_ticks: got %0d expected 1280", hd_cnt); end
        checks++; if (hs_cnt != 192)  begin failures++; $display("FAIL hsync_low_ticks: got %0d expected 192", hs_cnt); end
        checks++; if (fall_x != 656)  begin failures++; $display("FAIL hsync_start_x: got %0d expected 656", fall_x); end
        checks++; if (rise_x != 752)  begin failures++; $display("FAIL hsync_end_x: got %0d expected 752", rise_x); end
        checks++; if (ls_cnt != 2)    begin failures++; $display("FAIL line_start_count: got %0d expected 2", ls_cnt); end
    endtask

    task automatic test_pix_en_toggle();
        obs_t got, exp, prev;
        int hd_cycles = 0, run = 0, ls_first = -1, ls_gap = -1, ls_width = -1;
        bit pe;
        prev = sample(0);
        for (int i = 0; i < 3200; i++) begin
            pe = (i % 2 == 0);
            tick(0, pe);
            got = sample(0); exp = qa.pop_front(); checks++;
            if (got !== exp) begin failures++; $display("FAIL toggle cycle %0d: got %h expected %h", i, got, exp); end
            if (!pe) begin
                checks++;
                if (got !== prev) begin failures++; $display("FAIL frozen cycle %0d: got %h expected %h", i, got, prev); end
            end
            if (got.hd) hd_cycles++;
            if (got.ls && !prev.ls) begin
                if (ls_first < 0) ls_first = i; else ls_gap = i - ls_first;
                run = 0;
            end
            if (got.ls) run++;
            if (!got.ls && prev.ls) ls_width = run;
            prev = got;
        end
        checks++; if (hd_cycles != 2560) begin failures++; $display("FAIL toggle_h_display_cycles: got %0d expected 2560", hd_cycles); end
        checks++; if (ls_gap != 1600)    begin failures++; $display("FAIL toggle_line_period: got %0d expected 1600", ls_gap); end
        checks++; if (ls_width != 2)     begin failures++; $display("FAIL toggle_pulse_width: got %0d expected 2", ls_width); end
    endtask

    task automatic test_async_reset();
        obs_t got, exp;
        bit found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick(0, 1'b1);
            got = sample(0); exp = qa.pop_front(); checks++;
            if (got !== exp) begin failures++; $display("FAIL seek tick %0d: got %h expected %h", i, got, exp); end
            if (got.x === 10'd700) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL seek_timeout: got no x=700 expected x=700 within 2000 ticks"); end
        checks++;
        if (got.hs !== 1'b0) begin failures++; $display("FAIL pre_reset_hsync: got %b expected 0", got.hs); end
        #2;
        rst_a_n = 1'b0;
        #1;
        got = sample(0); checks++;
        if (got !== reset_obs(0)) begin failures++; $display("FAIL async_reset_immediate: got %h expected %h", got, reset_obs(0)); end
        @(posedge clk);
        #1;
        got = sample(0); checks++;
        if (got !== reset_obs(0)) begin failures++; $display("FAIL async_reset_hold: got %h expected %h", got, reset_obs(0)); end
        rst_a_n = 1'b1;
        model_reset(0);
        for (int i = 0; i < 20; i++) begin
            tick(0, 1'b1);
            got = sample(0); exp = qa.pop_front(); checks++;
            if (got !== exp) begin failures++; $display("FAIL restart tick %0d: got %h expected %h", i, got, exp); end
            if (i == 0) begin
                checks++;
                if (got.fs !== 1'b1 || got.x !== 10'd0 || got.y !== 10'd0) begin
                    failures++; $display("FAIL restart_origin: got %h expected fs=1 x=0 y=0", got);
                end
            end
        end
    endtask

    task automatic test_small_frame();
        obs_t got, exp, prev;
        int hs_cnt = 0, vs_cnt = 0, x_wraps = 0, y_wraps = 0, fs_prev = -1, hs_rise_x = -1, vs_rise_y = -1;
        got = sample(1); checks++;
        if (got !== reset_obs(1)) begin failures++; $display("FAIL small_reset: got %h expected %h", got, reset_obs(1)); end
        rst_b_n = 1'b1;
        model_reset(1);
        prev = got;
        for (int i = 0; i < 200; i++) begin
            tick(1, 1'b1);
            got = sample(1); exp = qb.pop_front(); checks++;
            if (got !== exp) begin failures++; $display("FAIL small tick %0d: got %h expected %h", i, got, exp); end
            if (got.hs) hs_cnt++;
            if (got.vs) vs_cnt++;
            if (!prev.hs && got.hs && hs_rise_x < 0) hs_rise_x = int'(got.x);
            if (!prev.vs && got.vs && vs_rise_y < 0) vs_rise_y = int'(got.y);
            if (prev.x === 10'd11 && got.x === 10'd0) x_wraps++;
            if (prev.y === 10'd6 && got.y === 10'd0) y_wraps++;
            if (got.fs) begin
                if (fs_prev >= 0) begin
                    checks++;
                    if (i - fs_prev != 84) begin failures++; $display("FAIL small_frame_period: got %0d expected 84", i - fs_prev); end
                end
                fs_prev = i;
            end
            prev = got;
        end
        checks++; if (hs_cnt != 32)    begin failures++; $display("FAIL small_hsync_ticks: got %0d expected 32", hs_cnt); end
        checks++; if (vs_cnt != 24)    begin failures++; $display("FAIL small_vsync_ticks: got %0d expected 24", vs_cnt); end
        checks++; if (hs_rise_x != 9)  begin failures++; $display("FAIL small_hsync_x: got %0d expected 9", hs_rise_x); end
        checks++; if (vs_rise_y != 5)  begin failures++; $display("FAIL small_vsync_y: got %0d expected 5", vs_rise_y); end
        checks++; if (x_wraps != 16)   begin failures++; $display("FAIL small_x_wraps: got %0d expected 16", x_wraps); end
        checks++; if (y_wraps != 2)    begin failures++; $display("FAIL small_y_wraps: got %0d expected 2", y_wraps); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lines();
        test_pix_en_toggle();
        test_async_reset();
        test_small_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
